// File: rtl/runner_field_engine.sv
// Runner game playfield engine: scrolling obstacle grid, dino jump state,
// score/speed level and the IDLE/RUN/PAUSED/OVER game state machine.
module runner_field_engine #(
  parameter int COLS          = 16,
  parameter int LANES         = 2,
  parameter int TYPE_W        = 2,
  parameter int TICK_DIV      = 250000,
  parameter int JUMP_TICKS    = 3,
  parameter int MIN_GAP       = 2,
  parameter int SPEEDUP_EVERY = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic                          pause,
  input  logic                          jump,
  input  logic                          force_over,
  input  logic [15:0]                   rand_val,
  output logic [COLS*LANES*TYPE_W-1:0]  field_flat,
  output logic                          dino_air,
  output logic [31:0]                   score,
  output logic [1:0]                    level,
  output logic                          tick,
  output logic                          game_over,
  output logic                          running
);

  localparam int FW    = COLS * LANES * TYPE_W;
  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int AIR_W = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS + 1) : 1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_OVER} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    field_q, field_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [AIR_W-1:0] air_q, air_d;
  logic             dino_q, dino_d;
  logic [31:0]      score_q, score_d;
  logic [1:0]       level_q, level_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] period;
  logic             wrap;
  logic [FW-1:0]    scrolled;
  logic             spawn_ok;
  logic [1:0]       spawn_type;
  logic [31:0]      score_inc;
  logic [31:0]      level_full;
  logic             jump_ok;
  logic             hit;
  logic             unused_rand;

  assign unused_rand = ^rand_val[15:6];

  // Period shrinks with level; clamp so very high levels still tick every cycle.
  always_comb begin
    period = DIV_W'(TICK_DIV) >> level_q;
    if (period == '0) period = DIV_W'(1);
    wrap = ({1'b0, div_q} + (DIV_W + 1)'(1)) >= {1'b0, period};
  end

  always_comb begin
    spawn_ok   = (gap_q >= GAP_W'(MIN_GAP)) && (rand_val[3:0] < 4'd5);
    spawn_type = (rand_val[5:4] == 2'd0) ? 2'd1 : rand_val[5:4];
    scrolled   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned c = 0; c + 1 < COLS; c++) begin
        scrolled[(l*COLS + c)*TYPE_W +: TYPE_W] = field_q[(l*COLS + c + 1)*TYPE_W +: TYPE_W];
      end
    end
    if (spawn_ok) begin
      if (spawn_type == 2'd3)
        scrolled[((LANES-1)*COLS + COLS-1)*TYPE_W +: TYPE_W] = TYPE_W'(spawn_type);
      else
        scrolled[(COLS-1)*TYPE_W +: TYPE_W] = TYPE_W'(spawn_type);
    end
  end

  always_comb begin
    score_inc  = (score_q == '1) ? score_q : score_q + 32'd1;
    level_full = score_inc / 32'(SPEEDUP_EVERY);
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    div_d   = div_q;
    gap_d   = gap_q;
    air_d   = air_q;
    dino_d  = dino_q;
    score_d = score_q;
    level_d = level_q;
    tick_d  = 1'b0;
    jump_ok = 1'b0;
    hit     = 1'b0;
    if (state_q != S_RUN && start) begin
      state_d = S_RUN;
      field_d = '0;
      div_d   = '0;
      gap_d   = GAP_W'(MIN_GAP);
      air_d   = '0;
      dino_d  = 1'b0;
      score_d = '0;
      level_d = '0;
    end else begin
      case (state_q)
        S_PAUSED: if (pause) state_d = S_RUN;
        S_RUN: begin
          if (force_over) begin
            state_d = S_OVER;
          end else if (pause) begin
            state_d = S_PAUSED;
          end else begin
            jump_ok = jump && !dino_q;
            if (jump_ok) begin
              dino_d = 1'b1;
              air_d  = AIR_W'(JUMP_TICKS);
            end
            if (wrap) begin
              div_d  = '0;
              tick_d = 1'b1;
              // A jump landing on the tick edge keeps its full airtime.
              if (!jump_ok && air_q != '0) begin
                air_d = air_q - AIR_W'(1);
                if (air_q == AIR_W'(1)) dino_d = 1'b0;
              end
              field_d = scrolled;
              if (spawn_ok)                   gap_d = '0;
              else if (gap_q < GAP_W'(MIN_GAP)) gap_d = gap_q + GAP_W'(1);
              hit = dino_d ? |scrolled[COLS*TYPE_W +: TYPE_W] : |scrolled[0 +: TYPE_W];
              if (hit) begin
                state_d = S_OVER;
              end else begin
                score_d = score_inc;
                level_d = (level_full > 32'd3) ? 2'd3 : level_full[1:0];
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      field_q <= '0;
      div_q   <= '0;
      gap_q   <= GAP_W'(MIN_GAP);
      air_q   <= '0;
      dino_q  <= 1'b0;
      score_q <= '0;
      level_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      air_q   <= air_d;
      dino_q  <= dino_d;
      score_q <= score_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  assign field_flat = field_q;
  assign dino_air   = dino_q;
  assign score      = score_q;
  assign level      = level_q;
  assign tick       = tick_q;
  assign game_over  = (state_q == S_OVER);
  assign running    = (state_q == S_RUN);

endmodule

// File: tb/tb_runner_field_engine.sv
// Directed and randomized checks of runner_field_engine against a cycle-level
// behavioural model of the game rules built on a plain 2-D obstacle array.
module tb_runner_field_engine;

  localparam int COLS          = 16;
  localparam int LANES         = 2;
  localparam int TYPE_W        = 2;
  localparam int TICK_DIV      = 16;
  localparam int JUMP_TICKS    = 3;
  localparam int MIN_GAP       = 2;
  localparam int SPEEDUP_EVERY = 4;
  localparam int FW            = COLS * LANES * TYPE_W;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          jump = 1'b0;
  logic          force_over = 1'b0;
  logic [15:0]   rand_val = '0;
  logic [FW-1:0] field_flat;
  logic          dino_air;
  logic [31:0]   score;
  logic [1:0]    level;
  logic          tick;
  logic          game_over;
  logic          running;

  runner_field_engine #(
    .COLS(COLS), .LANES(LANES), .TYPE_W(TYPE_W), .TICK_DIV(TICK_DIV),
    .JUMP_TICKS(JUMP_TICKS), .MIN_GAP(MIN_GAP), .SPEEDUP_EVERY(SPEEDUP_EVERY)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .pause(pause), .jump(jump),
    .force_over(force_over), .rand_val(rand_val), .field_flat(field_flat),
    .dino_air(dino_air), .score(score), .level(level), .tick(tick),
    .game_over(game_over), .running(running)
  );

  always #5 CLK = ~CLK;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_OVER} mstate_t;

  mstate_t m_state = M_IDLE;
  int      m_field [COLS][LANES];
  int      m_div, m_gap, m_air, m_level;
  bit      m_dino, m_tick;
  longint  m_score;
  int      n_assert = 0;
  int      n_fail = 0;
  logic [15:0] cur_rand = '0;

  task automatic m_clear();
    for (int c = 0; c < COLS; c++)
      for (int l = 0; l < LANES; l++) m_field[c][l] = 0;
    m_div = 0; m_gap = MIN_GAP; m_air = 0; m_dino = 0; m_score = 0; m_level = 0;
  endtask

  task automatic model_edge();
    int period, ty, lane;
    bit jumped;
    m_tick = 0;
    if (RST) begin
      m_state = M_IDLE;
      m_clear();
    end else if (m_state != M_RUN && start) begin
      m_clear();
      m_state = M_RUN;
    end else if (m_state == M_PAUSED) begin
      if (pause) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (force_over) m_state = M_OVER;
      else if (pause) m_state = M_PAUSED;
      else begin
        jumped = jump && !m_dino;
        if (jumped) begin m_dino = 1; m_air = JUMP_TICKS; end
        period = TICK_DIV >> m_level;
        if (period < 1) period = 1;
        if (m_div + 1 >= period) begin
          m_div = 0;
          m_tick = 1;
          if (!jumped && m_air > 0) begin
            m_air--;
            if (m_air == 0) m_dino = 0;
          end
          for (int l = 0; l < LANES; l++) begin
            for (int c = 0; c < COLS - 1; c++) m_field[c][l] = m_field[c+1][l];
            m_field[COLS-1][l] = 0;
          end
          if (m_gap >= MIN_GAP && rand_val[3:0] < 4'd5) begin
            ty = int'(rand_val[5:4]);
            if (ty == 0) ty = 1;
            lane = (ty == 3) ? LANES - 1 : 0;
            m_field[COLS-1][lane] = ty;
            m_gap = 0;
          end else if (m_gap < MIN_GAP) m_gap++;
          if (m_field[0][m_dino ? 1 : 0] != 0) m_state = M_OVER;
          else begin
            if (m_score < 64'hFFFF_FFFF) m_score++;
            m_level = (m_score / SPEEDUP_EVERY >= 3) ? 3 : int'(m_score / SPEEDUP_EVERY);
          end
        end else m_div++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] ef;
    ef = '0;
    for (int l = 0; l < LANES; l++)
      for (int c = 0; c < COLS; c++) ef[(l*COLS + c)*TYPE_W +: TYPE_W] = TYPE_W'(m_field[c][l]);
    chk("field_flat", 64'(field_flat), ef);
    chk("dino_air", 64'(dino_air), 64'(m_dino));
    chk("score", 64'(score), 64'(m_score));
    chk("level", 64'(level), 64'(m_level));
    chk("tick", 64'(tick), 64'(m_tick));
    chk("game_over", 64'(game_over), 64'(m_state == M_OVER));
    chk("running", 64'(running), 64'(m_state == M_RUN));
  endtask

  task automatic step(input bit st, input bit ps, input bit jp, input bit fo, input bit rs);
    start = st; pause = ps; jump = jp; force_over = fo; RST = rs; rand_val = cur_rand;
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_score(input longint target, input int budget);
    for (int i = 0; i < budget && score != 32'(target) && !game_over; i++) idle(1);
  endtask

  task automatic wait_over(input int budget);
    for (int i = 0; i < budget && !game_over; i++) idle(1);
  endtask

  initial begin
    int cnt;
    logic prev_air;

    // Reset and idle: nothing moves before start
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(TICK_DIV + 4);

    // Scroll/spawn, then ground collision with the dino staying down
    cur_rand = 16'h0010;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * TICK_DIV && !tick; i++) idle(1);
    chk("t2_spawn_col15", 64'(field_flat[(COLS-1)*TYPE_W +: TYPE_W]), 64'd1);
    idle(TICK_DIV);
    chk("t2_scroll_col14", 64'(field_flat[(COLS-2)*TYPE_W +: TYPE_W]), 64'd1);
    chk("t2_gap_col15", 64'(field_flat[(COLS-1)*TYPE_W +: TYPE_W]), 64'd0);
    wait_over(2000);
    chk("t3_over", 64'(game_over), 64'd1);
    chk("t3_score", 64'(score), 64'd15);

    // Mid-run reset
    cur_rand = 16'h000F;
    step(1, 0, 0, 0, 0);
    idle(30);
    step(0, 0, 0, 0, 1);
    chk("t1_score", 64'(score), 64'd0);
    chk("t1_running", 64'(running), 64'd0);
    cnt = 0;
    for (int i = 0; i < TICK_DIV; i++) begin idle(1); cnt += int'(tick); end
    chk("t1_no_tick", 64'(cnt), 64'd0);

    // Jump over the first ground obstacle; second jump while airborne ignored
    cur_rand = 16'h0010;
    step(1, 0, 0, 0, 0);
    wait_score(15, 2000);
    chk("t4_pre_score", 64'(score), 64'd15);
    step(0, 0, 1, 0, 0);
    prev_air = dino_air;
    cnt = 0;
    for (int i = 0; i < 200 && !game_over; i++) begin
      step(0, 0, (i == 2), 0, 0);
      if (tick && prev_air) cnt++;
      prev_air = dino_air;
    end
    chk("t4_air_ticks", 64'(cnt), 64'd3);
    chk("t4_score", 64'(score), 64'd18);

    // Flyers: safe on the ground, fatal when jumped into
    cur_rand = 16'h0030;
    step(1, 0, 0, 0, 0);
    wait_score(20, 2000);
    chk("t5_ground_score", 64'(score), 64'd20);
    chk("t5_ground_alive", 64'(game_over), 64'd0);
    for (int i = 0; i < 200 && !(m_field[1][LANES-1] != 0 && !m_dino); i++) idle(1);
    step(0, 0, 1, 0, 0);
    wait_over(20);
    chk("t5_flyer_hit", 64'(game_over), 64'd1);

    // Pause freeze, force_over priority over pause
    cur_rand = 16'h000F;
    step(1, 0, 0, 0, 0);
    idle(40);
    step(0, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 10 * TICK_DIV; i++) begin idle(1); cnt += int'(tick); end
    chk("t6_pause_ticks", 64'(cnt), 64'd0);
    step(0, 1, 0, 0, 0);
    idle(20);
    step(0, 1, 0, 1, 0);
    chk("t6_force_over", 64'(game_over), 64'd1);

    // Speed level 2 at score 8 gives a TICK_DIV/4 period
    step(1, 0, 0, 0, 0);
    wait_score(8, 1000);
    chk("t6_level", 64'(level), 64'd2);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1);
      cnt++;
      if (tick) break;
    end
    chk("t6_period", 64'(cnt), 64'(TICK_DIV / 4));

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      cur_rand = 16'($urandom);
      step(($urandom % 40) == 0, ($urandom % 60) == 0, ($urandom % 6) == 0,
           ($urandom % 300) == 0, ($urandom % 700) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
